fht_frame_sequencer: RTL and testbench

Frame-level sequencer wrapped around the FHT core. Accepts a stream of ADC samples, scatters them across the core's four RAM(A) banks, pulses the core start, waits for the transform to finish, then reads the four banks back out as an ordered, back-pressured result stream. It owns every external core port (`iDATA`, `iADDR_WR`, `iWE_0..3`, `iSTART`, `iADDR_RD_0..3`, `oDATA_0..3`, `oRDY`), so no other logic drives the core.

---
 rtl/fht_frame_sequencer_if.sv | 41 ++++
 rtl/fht_frame_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fht_frame_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fht_frame_sequencer_if.sv
// Signal bundle between the FHT frame sequencer and its environment (sample
// source, FHT core, result sink). The master modport is the sequencer's view.
`timescale 1ns/1ps
interface fht_frame_sequencer_if #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8
);
  logic                    iENABLE;
  logic [D_BIT-2:0]        iS_DATA;
  logic                    iS_VALID;
  logic                    oS_READY;
  logic [D_BIT-2:0]        oC_DATA;
  logic [A_BIT-1:0]        oC_ADDR_WR;
  logic [3:0]              oC_WE;
  logic                    oC_START;
  logic                    iC_RDY;
  logic [A_BIT-1:0]        oC_ADDR_RD;
  logic signed [D_BIT-1:0] iC_DATA_0;
  logic signed [D_BIT-1:0] iC_DATA_1;
  logic signed [D_BIT-1:0] iC_DATA_2;
  logic signed [D_BIT-1:0] iC_DATA_3;
  logic signed [D_BIT-1:0] oM_DATA;
  logic                    oM_VALID;
  logic                    oM_LAST;
  logic                    iM_READY;
  logic                    oBUSY;

  modport master (
    input  iENABLE, iS_DATA, iS_VALID, iC_RDY,
           iC_DATA_0, iC_DATA_1, iC_DATA_2, iC_DATA_3, iM_READY,
    output oS_READY, oC_DATA, oC_ADDR_WR, oC_WE, oC_START, oC_ADDR_RD,
           oM_DATA, oM_VALID, oM_LAST, oBUSY
  );

  modport slave (
    output iENABLE, iS_DATA, iS_VALID, iC_RDY,
           iC_DATA_0, iC_DATA_1, iC_DATA_2, iC_DATA_3, iM_READY,
    input  oS_READY, oC_DATA, oC_ADDR_WR, oC_WE, oC_START, oC_ADDR_RD,
           oM_DATA, oM_VALID, oM_LAST, oBUSY
  );
endinterface

// File: rtl/fht_frame_sequencer.sv
// Frame sequencer around the FHT core: scatters a sample frame over the four
// RAM(A) banks, kicks the core, then streams the banks back out in index order.
//
// state     | meaning
// S_IDLE    | no frame; waits for iENABLE
// S_LOAD    | accepting samples, one core bank write per handshake
// S_KICK    | all samples written; launches the one-cycle core start
// S_WAIT_LO | waits for the core to drop oRDY (start acknowledged)
// S_WAIT_HI | waits for the core to raise oRDY (transform done)
// S_UNLOAD  | credit-limited bank reads feeding the result FIFO
`timescale 1ns/1ps
module fht_frame_sequencer #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 2
) (
  input logic                   iCLK,
  input logic                   iRESET,
  fht_frame_sequencer_if.master bus
);
  localparam int N     = 4 * (2 ** A_BIT);
  localparam int J_BIT = A_BIT + 2;
  localparam int DEPTH = RD_LAT + 1;
  localparam int P_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_BIT = $clog2(2 * DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT_LO, S_WAIT_HI, S_UNLOAD
  } state_t;

  state_t                  r_state;
  logic                    r_s_ready;
  logic [D_BIT-2:0]        r_c_data;
  logic [A_BIT-1:0]        r_c_addr_wr;
  logic [3:0]              r_c_we;
  logic                    r_c_start;
  logic [A_BIT-1:0]        r_c_addr_rd;
  logic [J_BIT-1:0]        r_wr_idx;
  logic [J_BIT-1:0]        r_rd_idx;
  logic                    r_issue_done;
  logic                    r_pipe_vld  [RD_LAT];
  logic [1:0]              r_pipe_tag  [RD_LAT];
  logic                    r_pipe_last [RD_LAT];
  logic signed [D_BIT-1:0] r_fifo_data [DEPTH];
  logic                    r_fifo_last [DEPTH];
  logic [P_BIT-1:0]        r_wr_ptr;
  logic [P_BIT-1:0]        r_rd_ptr;
  logic [C_BIT-1:0]        r_count;

  logic                    w_s_hs;
  logic                    w_m_valid;
  logic                    w_m_pop;
  logic                    w_head_last;
  logic                    w_issue;
  logic [C_BIT-1:0]        w_inflight;
  logic [C_BIT-1:0]        w_used;
  logic                    w_ret_vld;
  logic                    w_ret_last;
  logic signed [D_BIT-1:0] w_ret_data;

  // The core output is taken RD_LAT cycles after the issue cycle, when the
  // matching tag leaves the pipe. A slot freed by this cycle's pop may be
  // reused right away, which is what sustains one result per cycle.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < RD_LAT; k++)
      w_inflight = w_inflight + C_BIT'(r_pipe_vld[k]);
    w_s_hs      = bus.iS_VALID && r_s_ready;
    w_m_valid   = (r_count != '0);
    w_head_last = r_fifo_last[r_rd_ptr];
    w_m_pop     = w_m_valid && bus.iM_READY;
    w_used      = w_inflight + r_count - C_BIT'(w_m_pop);
    w_issue     = (r_state == S_UNLOAD) && !r_issue_done && (w_used < C_BIT'(DEPTH));
    w_ret_vld   = r_pipe_vld[RD_LAT-1];
    w_ret_last  = r_pipe_last[RD_LAT-1];
    case (r_pipe_tag[RD_LAT-1])
      2'd0:    w_ret_data = bus.iC_DATA_0;
      2'd1:    w_ret_data = bus.iC_DATA_1;
      2'd2:    w_ret_data = bus.iC_DATA_2;
      default: w_ret_data = bus.iC_DATA_3;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state      <= S_IDLE;
      r_s_ready    <= 1'b0;
      r_c_data     <= '0;
      r_c_addr_wr  <= '0;
      r_c_we       <= '0;
      r_c_start    <= 1'b0;
      r_c_addr_rd  <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_issue_done <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_pipe_vld[k]  <= 1'b0;
        r_pipe_tag[k]  <= '0;
        r_pipe_last[k] <= 1'b0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        r_fifo_data[k] <= '0;
        r_fifo_last[k] <= 1'b0;
      end
    end else begin
      r_c_we    <= '0;
      r_c_start <= 1'b0;

      r_pipe_vld[0]  <= w_issue;
      r_pipe_tag[0]  <= r_rd_idx[1:0];
      r_pipe_last[0] <= (r_rd_idx == J_BIT'(N - 1));
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipe_vld[k]  <= r_pipe_vld[k-1];
        r_pipe_tag[k]  <= r_pipe_tag[k-1];
        r_pipe_last[k] <= r_pipe_last[k-1];
      end
      if (w_issue) begin
        r_c_addr_rd <= r_rd_idx[J_BIT-1:2];
        r_rd_idx    <= r_rd_idx + J_BIT'(1);
        if (r_rd_idx == J_BIT'(N - 1))
          r_issue_done <= 1'b1;
      end

      if (w_ret_vld) begin
        r_fifo_data[r_wr_ptr] <= w_ret_data;
        r_fifo_last[r_wr_ptr] <= w_ret_last;
        r_wr_ptr <= (r_wr_ptr == P_BIT'(DEPTH - 1)) ? '0 : r_wr_ptr + P_BIT'(1);
      end
      if (w_m_pop)
        r_rd_ptr <= (r_rd_ptr == P_BIT'(DEPTH - 1)) ? '0 : r_rd_ptr + P_BIT'(1);
      r_count <= r_count + C_BIT'(w_ret_vld) - C_BIT'(w_m_pop);

      case (r_state)
        S_IDLE: begin
          if (bus.iENABLE) begin
            r_state   <= S_LOAD;
            r_s_ready <= 1'b1;
            r_wr_idx  <= '0;
          end
        end
        S_LOAD: begin
          if (w_s_hs) begin
            r_c_data    <= bus.iS_DATA;
            r_c_addr_wr <= r_wr_idx[J_BIT-1:2];
            r_c_we      <= 4'b0001 << r_wr_idx[1:0];
            r_wr_idx    <= r_wr_idx + J_BIT'(1);
            if (r_wr_idx == J_BIT'(N - 1)) begin
              r_state   <= S_KICK;
              r_s_ready <= 1'b0;
            end
          end
        end
        S_KICK: begin
          r_c_start <= 1'b1;
          r_state   <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!bus.iC_RDY)
            r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (bus.iC_RDY) begin
            r_state      <= S_UNLOAD;
            r_rd_idx     <= '0;
            r_issue_done <= 1'b0;
          end
        end
        S_UNLOAD: begin
          if (w_m_pop && w_head_last)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oS_READY   = r_s_ready;
  assign bus.oC_DATA    = r_c_data;
  assign bus.oC_ADDR_WR = r_c_addr_wr;
  assign bus.oC_WE      = r_c_we;
  assign bus.oC_START   = r_c_start;
  assign bus.oC_ADDR_RD = r_c_addr_rd;
  assign bus.oM_DATA    = r_fifo_data[r_rd_ptr];
  assign bus.oM_VALID   = w_m_valid;
  assign bus.oM_LAST    = w_m_valid && w_head_last;
  assign bus.oBUSY      = (r_state != S_IDLE);
endmodule

// File: tb/tb_fht_frame_sequencer.sv
// Directed bench for fht_frame_sequencer with N=16 frames and a simple core
// model that returns bank*100+addr one register stage after the read address.
`timescale 1ns/1ps
module tb_fht_frame_sequencer;
  localparam int D_BIT  = 16;
  localparam int A_BIT  = 2;
  localparam int RD_LAT = 2;
  localparam int N      = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [A_BIT-1:0] rd_addr_q;

  fht_frame_sequencer_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

  fht_frame_sequencer #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core read path: data reflects the read address one cycle later.
  always @(posedge clk) rd_addr_q <= bus.oC_ADDR_RD;
  assign bus.iC_DATA_0 = 16'(rd_addr_q);
  assign bus.iC_DATA_1 = 16'(100) + 16'(rd_addr_q);
  assign bus.iC_DATA_2 = 16'(200) + 16'(rd_addr_q);
  assign bus.iC_DATA_3 = 16'(300) + 16'(rd_addr_q);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int base, input int bubble_at);
    bus.iENABLE  = 1'b1;
    bus.iS_VALID = 1'b0;
    tick();
    chk("load_ready_on", 32'(bus.oS_READY), 1);
    chk("load_busy", 32'(bus.oBUSY), 1);
    bus.iENABLE = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j == bubble_at) begin
        bus.iS_VALID = 1'b0;
        tick();
        chk("bubble_no_we", 32'(bus.oC_WE), 0);
        chk("bubble_ready", 32'(bus.oS_READY), 1);
      end
      bus.iS_VALID = 1'b1;
      bus.iS_DATA  = 15'(base + j);
      tick();
      chk("wr_we", 32'(bus.oC_WE), 32'(1 << (j % 4)));
      chk("wr_addr", 32'(bus.oC_ADDR_WR), 32'(j / 4));
      chk("wr_data", 32'(bus.oC_DATA), 32'(base + j));
      chk("wr_no_start", 32'(bus.oC_START), 0);
      chk("wr_ready", 32'(bus.oS_READY), (j < N - 1) ? 1 : 0);
    end
    bus.iS_VALID = 1'b0;
  endtask

  task automatic core_handshake(input bit check_latency);
    bit early;
    bit idle_seen;
    tick();
    chk("start_pulse", 32'(bus.oC_START), 1);
    chk("start_no_we", 32'(bus.oC_WE), 0);
    tick();
    chk("start_single", 32'(bus.oC_START), 0);
    repeat (2) tick();
    bus.iC_RDY = 1'b0;
    early     = 1'b0;
    idle_seen = 1'b0;
    repeat (40) begin
      tick();
      early     = early | bus.oM_VALID | bus.oC_START;
      idle_seen = idle_seen | !bus.oBUSY;
    end
    chk("no_result_before_rdy", 32'(early), 0);
    chk("busy_during_core", 32'(idle_seen), 0);
    bus.iC_RDY = 1'b1;
    if (check_latency) begin
      bus.iM_READY = 1'b0;
      for (int i = 1; i <= RD_LAT + 2; i++) begin
        tick();
        chk("first_valid_timing", 32'(bus.oM_VALID), (i == RD_LAT + 2) ? 1 : 0);
      end
      chk("first_result", 32'(bus.oM_DATA), 0);
      chk("first_not_last", 32'(bus.oM_LAST), 0);
    end
  endtask

  task automatic unload(input bit rnd, input int stop_after);
    int k, cyc, gaps;
    bit rdy, stalled, seen;
    logic signed [15:0] held;
    k = 0; cyc = 0; gaps = 0; stalled = 1'b0; seen = 1'b0; held = '0;
    while (k < stop_after && cyc < 400) begin
      if (stalled) begin
        chk("hold_valid", 32'(bus.oM_VALID), 1);
        chk("hold_data", 32'(bus.oM_DATA), 32'(held));
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.iM_READY = rdy;
      stalled = 1'b0;
      if (bus.oM_VALID) begin
        seen = 1'b1;
        if (rdy) begin
          chk("res_data", 32'(bus.oM_DATA), 32'((k % 4) * 100 + k / 4));
          chk("res_last", 32'(bus.oM_LAST), (k == N - 1) ? 1 : 0);
          k++;
        end else begin
          stalled = 1'b1;
          held    = bus.oM_DATA;
        end
      end else if (seen) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    chk("unload_count", 32'(k), 32'(stop_after));
    if (!rnd) chk("unload_gaps", 32'(gaps), 0);
  endtask

  initial begin
    bit acc;
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.iENABLE  = 1'b0;
    bus.iS_VALID = 1'b1;
    bus.iS_DATA  = 15'h1234;
    bus.iC_RDY   = 1'b1;
    bus.iM_READY = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_s_ready", 32'(bus.oS_READY), 0);
    chk("rst_we", 32'(bus.oC_WE), 0);
    chk("rst_start", 32'(bus.oC_START), 0);
    chk("rst_c_data", 32'(bus.oC_DATA), 0);
    chk("rst_addr_wr", 32'(bus.oC_ADDR_WR), 0);
    chk("rst_addr_rd", 32'(bus.oC_ADDR_RD), 0);
    chk("rst_m_valid", 32'(bus.oM_VALID), 0);
    chk("rst_m_last", 32'(bus.oM_LAST), 0);
    chk("rst_m_data", 32'(bus.oM_DATA), 0);
    chk("rst_busy", 32'(bus.oBUSY), 0);

    acc = 1'b0;
    repeat (5) begin
      tick();
      acc = acc | bus.oS_READY | (|bus.oC_WE) | bus.oBUSY | bus.oC_START;
    end
    chk("idle_quiet", 32'(acc), 0);
    bus.iS_VALID = 1'b0;

    // Frame 1: value = index, one input bubble, random result back-pressure.
    load_frame(0, 8);
    core_handshake(1'b1);
    unload(1'b1, N);
    chk("f1_done_busy", 32'(bus.oBUSY), 0);
    chk("f1_done_valid", 32'(bus.oM_VALID), 0);

    // Frame 2: full-rate unload, reset after seven results.
    load_frame(1000, -1);
    core_handshake(1'b0);
    unload(1'b0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.oM_VALID), 0);
    chk("midrst_busy", 32'(bus.oBUSY), 0);
    chk("midrst_ready", 32'(bus.oS_READY), 0);
    acc = 1'b0;
    repeat (4) begin
      tick();
      acc = acc | (|bus.oC_WE) | bus.oC_START | bus.oM_VALID | bus.oBUSY;
    end
    chk("midrst_quiet", 32'(acc), 0);

    // Frame 3: clean reload after the abandoned frame, full-rate unload.
    load_frame(2000, -1);
    core_handshake(1'b0);
    unload(1'b0, N);
    chk("f3_done_busy", 32'(bus.oBUSY), 0);
    chk("f3_done_valid", 32'(bus.oM_VALID), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
